ram_rr_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one single-port synchronous RAM among NUM_REQ requesters.
- Accepts at most one read or write per cycle, drives registered RAM control, and routes read data back to the owning requester.
- Sits between requester masters and the ram DUT; the existing ram environment drives its requester side.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_rr_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 39 +++
 rtl/ram_rr_arbiter.sv | 110 +++++++++++
 tb/tb_ram_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM-sharing arbiter family: default widths,
// request record layout and the requester-ID width helper.
package ram_arb_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

  // A single requester still needs one ID bit so owner registers never collapse to zero width.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Requester and RAM-side bundle of the shared-RAM arbiter; the arbiter is the
// slave, requesters plus the RAM model together form the master side.
interface ram_rr_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          ram_we;
  logic                          ram_re;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic [DATA_WIDTH-1:0]         ram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_we, ram_re, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_re, ram_addr, ram_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr (wrapping) wins.
// Purely combinational so callers can fold it into their own issue cycle.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDW-1:0]       off;
  logic [IDW:0]         sum;

  assign req_dbl = {req, req};
  assign any     = |req;

  always_comb begin
    req_rot = NUM_REQ'(req_dbl >> ptr);
    off     = '0;
    // Scan downward so the lowest rotated position (closest to ptr) is the last writer.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx = sum[IDW-1:0];
    gnt = any ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM among NUM_REQ
// requesters; issues one access per cycle and steers read data to its owner.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_rr_arbiter_if.slave bus
);

  localparam int             IDW      = id_width(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [IDW-1:0]        iss_owner_q, iss_owner_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]        rsp_owner_q, rsp_owner_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDW-1:0]        pick_idx;
  logic                  pick_any;
  logic                  accept;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grants are masked while reset is held so nothing is accepted that the reset edge would drop.
  assign accept        = rst_n && pick_any;
  assign bus.req_ready = rst_n ? pick_gnt : '0;

  always_comb begin
    ptr_d       = ptr_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    iss_owner_d = iss_owner_q;
    if (accept) begin
      ptr_d       = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDW'(1);
      ram_we_d    = bus.req_we[pick_idx];
      ram_re_d    = ~bus.req_we[pick_idx];
      ram_addr_d  = addr_a[pick_idx];
      ram_wdata_d = wdata_a[pick_idx];
      iss_owner_d = pick_idx;
    end
    // Owner rides one stage behind the RAM read so it lines up with ram_rdata.
    rsp_vld_d   = ram_re_q;
    rsp_owner_d = iss_owner_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      iss_owner_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      iss_owner_q <= iss_owner_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  // RAM data arrives in the same cycle as the registered owner strobe; gate it so idle reads as zero.
  assign bus.rsp_valid = rsp_vld_q ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << rsp_owner_q) : '0;
  assign bus.rsp_rdata = rsp_vld_q ? bus.ram_rdata : '0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_valid[g] && !bus.req_ready[g]) |=>
        (bus.req_valid[g] && $stable(bus.req_we[g]) && $stable(addr_a[g]) && $stable(wdata_a[g])));
  end

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Scoreboard bench for ram_rr_arbiter: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ram_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ram_rr_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(4)) b2 ();
  ram_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) b4 ();

  ram_rr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  ram_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Synchronous RAM behind the 2-requester arbiter: read data appears the cycle after ram_re.
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
    else if (b2.ram_we) ram_mem[b2.ram_addr] <= b2.ram_wdata;
    if (b2.ram_re) b2.ram_rdata <= ram_mem[b2.ram_addr];
  end
  assign b4.ram_rdata = 8'h00;

  typedef struct { int cyc; logic we; logic [3:0] addr; logic [7:0] wdata; } iss_t;
  typedef struct { int cyc; int owner; logic [7:0] data; } rsp_t;
  typedef struct { int cyc; logic [3:0] gnt; } gnt_t;

  iss_t iq[$];
  rsp_t rq[$];
  gnt_t gq[$];
  gnt_t g4q[$];
  int   zq[$];
  logic [7:0] mm [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  task automatic exp_g(input int c, input logic [1:0] g);
    gq.push_back('{cyc: c, gnt: {2'b00, g}});
  endtask
  task automatic exp_i(input int c, input logic we, input logic [3:0] a, input logic [7:0] d);
    iq.push_back('{cyc: c, we: we, addr: a, wdata: d});
  endtask
  task automatic exp_r(input int c, input int o, input logic [7:0] d);
    rq.push_back('{cyc: c, owner: o, data: d});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv2(input logic [1:0] v, input logic [1:0] we, input logic [3:0] a0,
                      input logic [3:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    b2.req_valid = v;
    b2.req_we    = we;
    b2.req_addr  = {a1, a0};
    b2.req_wdata = {d1, d0};
  endtask

  function automatic int pick2(input logic [1:0] v, input int p);
    for (int k = 0; k < 2; k++) begin
      if (v[(p + k) % 2]) return (p + k) % 2;
    end
    return -1;
  endfunction

  // Monitor: every negedge, compare whatever expectation is due this cycle.
  initial forever begin
    @(negedge clk);
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      chk("grant2", b2.req_ready, gq[0].gnt);
      void'(gq.pop_front());
    end
    if (g4q.size() > 0 && g4q[0].cyc == cyc) begin
      chk("grant4", b4.req_ready, g4q[0].gnt);
      void'(g4q.pop_front());
    end
    if (iq.size() > 0 && iq[0].cyc == cyc) begin
      iss_t e;
      e = iq.pop_front();
      chk("issue_we", b2.ram_we, e.we);
      chk("issue_re", b2.ram_re, !e.we);
      chk("issue_addr", b2.ram_addr, e.addr);
      if (e.we) chk("issue_wdata", b2.ram_wdata, e.wdata);
    end else if (b2.ram_we || b2.ram_re) begin
      chk("unexpected_issue", {b2.ram_we, b2.ram_re}, 2'b00);
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      rsp_t r;
      r = rq.pop_front();
      chk("rsp_valid", b2.rsp_valid, 32'(1) << r.owner);
      chk("rsp_rdata", b2.rsp_rdata, r.data);
    end else if (|b2.rsp_valid) begin
      chk("unexpected_rsp", b2.rsp_valid, 0);
    end
    if (zq.size() > 0 && zq[0] == cyc) begin
      void'(zq.pop_front());
      chk("zero_ctrl", {b2.ram_we, b2.ram_re, b2.rsp_valid}, 0);
      chk("zero_addr", b2.ram_addr, 0);
      chk("zero_wdata", b2.ram_wdata, 0);
      chk("zero_rdata", b2.rsp_rdata, 0);
    end
  end

  initial begin
    #40000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] v, we, pend, g;
    logic [3:0] a [2];
    logic [7:0] d [2];
    int ptr_m, acc, budget, w;

    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    b4.req_valid = '0; b4.req_we = '0; b4.req_addr = '0; b4.req_wdata = '0;

    // Reset: outputs zero, no grant even with requests present
    tick(); zq.push_back(cyc); exp_g(cyc, 2'b00);
    tick(); drv2(2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00); zq.push_back(cyc); exp_g(cyc, 2'b00);
    tick(); rst_n = 1'b1; mem_clr = 1'b0; drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    zq.push_back(cyc); exp_g(cyc, 2'b00);
    tick(); zq.push_back(cyc);

    // Single requester: write 3=A5 then read it back
    tick(); drv2(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b1, 4'h3, 8'hA5); mm[3] = 8'hA5;
    tick(); drv2(2'b01, 2'b00, 4'h3, 4'h0, 8'hA5, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b0, 4'h3, 8'h00); exp_r(cyc + 2, 0, 8'hA5);
    tick(); drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00); exp_g(cyc, 2'b00);

    // Preload addresses 1, 2, 4; pointer walks 1 -> 0 -> 1 -> 0
    tick(); drv2(2'b10, 2'b10, 4'h0, 4'h1, 8'h00, 8'h3C); exp_g(cyc, 2'b10);
    exp_i(cyc + 1, 1'b1, 4'h1, 8'h3C); mm[1] = 8'h3C;
    tick(); drv2(2'b01, 2'b01, 4'h2, 4'h0, 8'hC3, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b1, 4'h2, 8'hC3); mm[2] = 8'hC3;
    tick(); drv2(2'b10, 2'b10, 4'h0, 4'h4, 8'h00, 8'h5A); exp_g(cyc, 2'b10);
    exp_i(cyc + 1, 1'b1, 4'h4, 8'h5A); mm[4] = 8'h5A;

    // Contention from ptr=0: grants 0,1,0 with in-order responses
    tick(); drv2(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b0, 4'h1, 8'h00); exp_r(cyc + 2, 0, 8'h3C);
    tick(); drv2(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00); exp_g(cyc, 2'b10);
    exp_i(cyc + 1, 1'b0, 4'h2, 8'h00); exp_r(cyc + 2, 1, 8'hC3);
    tick(); drv2(2'b01, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b0, 4'h1, 8'h00); exp_r(cyc + 2, 0, 8'h3C);

    // Same-address hazard: write 7 then immediate read of 7 from the other requester
    tick(); drv2(2'b01, 2'b01, 4'h7, 4'h0, 8'h77, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b1, 4'h7, 8'h77); mm[7] = 8'h77;
    tick(); drv2(2'b10, 2'b00, 4'h0, 4'h7, 8'h00, 8'h00); exp_g(cyc, 2'b10);
    exp_i(cyc + 1, 1'b0, 4'h7, 8'h00); exp_r(cyc + 3, 1, 8'h77);
    // (response lands two cycles after this acceptance)
    rq[rq.size() - 1].cyc = cyc + 2;
    tick(); drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00); exp_g(cyc, 2'b00);

    // Mid-flight reset: req1 read in flight is dropped
    tick(); drv2(2'b10, 2'b00, 4'h0, 4'h3, 8'h00, 8'h00); exp_g(cyc, 2'b10);
    exp_i(cyc + 1, 1'b0, 4'h3, 8'h00);
    tick(); rst_n = 1'b0; drv2(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00); exp_g(cyc, 2'b00);
    tick(); rst_n = 1'b1; zq.push_back(cyc);
    drv2(2'b01, 2'b01, 4'h9, 4'h0, 8'h99, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b1, 4'h9, 8'h99); mm[9] = 8'h99;
    // Second reset after ptr moved to 1: the next grant must return to requester 0
    tick(); rst_n = 1'b0; drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00); exp_g(cyc, 2'b00);
    tick(); rst_n = 1'b1; zq.push_back(cyc);
    drv2(2'b11, 2'b00, 4'h9, 4'h3, 8'h00, 8'h00); exp_g(cyc, 2'b01);
    exp_i(cyc + 1, 1'b0, 4'h9, 8'h00); exp_r(cyc + 2, 0, 8'h99);
    tick(); drv2(2'b10, 2'b00, 4'h9, 4'h3, 8'h00, 8'h00); exp_g(cyc, 2'b10);
    exp_i(cyc + 1, 1'b0, 4'h3, 8'h00); exp_r(cyc + 2, 1, 8'hA5);
    tick(); drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00); exp_g(cyc, 2'b00);

    // Fairness on the 4-requester instance: 0,1,2,3 x3, then drain each after its grant
    b4.req_addr = {4'h3, 4'h2, 4'h1, 4'h0};
    for (int k = 0; k < 16; k++) begin
      tick();
      b4.req_valid = (k < 12) ? 4'b1111 : 4'(4'b1111 << (k - 12));
      g4q.push_back('{cyc: cyc, gnt: 4'(1 << (k % 4))});
    end
    tick(); b4.req_valid = 4'b0000;
    g4q.push_back('{cyc: cyc, gnt: 4'b0000});

    // Back-to-back mixed traffic against the reference model
    ptr_m = 0; acc = 0; budget = 0; pend = 2'b00; v = 2'b00; we = 2'b00;
    a[0] = 4'h0; a[1] = 4'h0; d[0] = 8'h00; d[1] = 8'h00;
    while ((acc < 100 || pend != 2'b00) && budget < 400) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if (acc < 100 && $urandom_range(3) != 0) begin
            v[r]  = 1'b1;
            we[r] = 1'($urandom_range(1));
            a[r]  = 4'($urandom_range(7));
            d[r]  = 8'($urandom);
          end else begin
            v[r] = 1'b0;
          end
        end
      end
      drv2(v, we, a[0], a[1], d[0], d[1]);
      w = pick2(v, ptr_m);
      g = (w < 0) ? 2'b00 : 2'(1 << w);
      exp_g(cyc, g);
      if (w >= 0) begin
        exp_i(cyc + 1, we[w], a[w], d[w]);
        if (we[w]) mm[a[w]] = d[w];
        else exp_r(cyc + 2, w, mm[a[w]]);
        ptr_m = (w + 1) % 2;
        acc++;
      end
      pend = v & ~g;
      budget++;
    end
    chk("rand_accepted", (acc >= 100) ? 1 : 0, 1);
    tick(); drv2(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);

    repeat (5) tick();
    chk("issue_queue_drained", iq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);
    chk("grant_queue_drained", gq.size() + g4q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
